// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared encodings for the multi-cycle MIPS controller: opcode and funct
// values, datapath select encodings, the FSM state enum and a small
// instruction classifier used by both the FSM and the ALU decoder.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes (Inst_code[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (Inst_code[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_XOR = 3'b010, ALU_NOR = 3'b011,
        ALU_ADD = 3'b100, ALU_SUB = 3'b101, ALU_SLT = 3'b110, ALU_SLL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_JR = 2'b01, PC_BR = 2'b10, PC_JMP = 2'b11} pc_s_e;
    typedef enum logic [1:0] {WR_RD = 2'b00, WR_RT = 2'b01, WR_RA = 2'b10} w_r_s_e;
    typedef enum logic [1:0] {WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC4 = 2'b10} wr_data_s_e;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

    // Coarse instruction classes; everything the FSM sequences on.
    typedef enum logic [3:0] {
        IC_R, IC_JR, IC_J, IC_JAL, IC_BEQ, IC_BNE, IC_ADDI,
        IC_LOGI, IC_LUI, IC_LW, IC_SW, IC_ILL
    } instr_class_e;

    function automatic instr_class_e classify(input logic [5:0] opcode, input logic [5:0] funct);
        instr_class_e ic;
        ic = IC_ILL;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_JR:  ic = IC_JR;
                    FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT: ic = IC_R;
                    default: ic = IC_ILL;
                endcase
            end
            OP_J:    ic = IC_J;
            OP_JAL:  ic = IC_JAL;
            OP_BEQ:  ic = IC_BEQ;
            OP_BNE:  ic = IC_BNE;
            OP_ADDI: ic = IC_ADDI;
            OP_ANDI, OP_ORI, OP_XORI: ic = IC_LOGI;
            OP_LUI:  ic = IC_LUI;
            OP_LW:   ic = IC_LW;
            OP_SW:   ic = IC_SW;
            default: ic = IC_ILL;
        endcase
        return ic;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the multi-cycle controller (master) and the datapath (slave).
//   opcode/funct/ZF : decode and branch inputs from the datapath
//   PC_Write..illegal: datapath selects, write enables and status
// -----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ZF;
    logic       PC_Write;
    logic       IR_Write;
    logic [1:0] PC_s;
    logic       Write_Reg;
    logic [1:0] w_r_s;
    logic [1:0] wr_data_s;
    logic       rt_imm_s;
    logic       imm_s;
    logic [2:0] ALU_OP;
    logic       Mem_Write;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct, ZF,
        output PC_Write, IR_Write, PC_s, Write_Reg, w_r_s, wr_data_s,
               rt_imm_s, imm_s, ALU_OP, Mem_Write, instr_done, illegal
    );

    modport slave (
        output opcode, funct, ZF,
        input  PC_Write, IR_Write, PC_s, Write_Reg, w_r_s, wr_data_s,
               rt_imm_s, imm_s, ALU_OP, Mem_Write, instr_done, illegal
    );
endinterface

// File: rtl/mips_alu_dec.sv
// -----------------------------------------------------------------------------
// mips_alu_dec
// Combinational ALU control decoder.
//   opcode, funct : held instruction fields
//   state         : current controller state
//   alu_op        : ALU operation
//   imm_s         : 1 sign-extend / 0 zero-extend the immediate
//   rt_imm_s      : ALU B operand, 0 R_Data_B / 1 immediate
// The ALU setting chosen in EX is held through MEM and WB so that the
// address (lw/sw) and the result written back (R/I-ALU) stay valid without
// an ALU output register. IF and ID leave the ALU controls at zero.
// -----------------------------------------------------------------------------
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  state_e     state,
    output logic [2:0] alu_op,
    output logic       imm_s,
    output logic       rt_imm_s
);

    instr_class_e ic;

    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        ic       = classify(opcode, funct);
        alu_op   = ALU_AND;
        imm_s    = 1'b0;
        rt_imm_s = 1'b0;
        if (state inside {S_EX, S_MEM, S_WB}) begin
            unique case (ic)
                IC_R: begin
                    unique case (funct)
                        FN_ADD:  alu_op = ALU_ADD;
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_OR:   alu_op = ALU_OR;
                        FN_XOR:  alu_op = ALU_XOR;
                        FN_NOR:  alu_op = ALU_NOR;
                        FN_SLT:  alu_op = ALU_SLT;
                        FN_SLL:  alu_op = ALU_SLL;
                        default: alu_op = ALU_AND;
                    endcase
                end
                IC_ADDI, IC_LW, IC_SW: begin
                    alu_op   = ALU_ADD;
                    rt_imm_s = 1'b1;
                    imm_s    = 1'b1;
                end
                IC_LOGI: begin
                    unique case (opcode)
                        OP_ORI:  alu_op = ALU_OR;
                        OP_XORI: alu_op = ALU_XOR;
                        default: alu_op = ALU_AND;
                    endcase
                    rt_imm_s = 1'b1;
                end
                // Datapath applies the fixed 16-bit shift; B is the raw immediate.
                IC_LUI: begin
                    alu_op   = ALU_SLL;
                    rt_imm_s = 1'b1;
                end
                IC_BEQ, IC_BNE: begin
                    alu_op = ALU_SUB;
                    imm_s  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) for the MIPS R/I/J datapath.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset; forces every output to 0
//   bus   : mips_multicycle_ctrl_if.master (decode inputs, datapath controls)
// Parameters: MEM_WAIT extra MEM cycles for lw/sw (0..15); OP_W field width.
// Build option: define ILLEGAL_TRAP_EN to send illegal instructions to a
// HALT state (illegal=1, all enables 0) until reset; otherwise they retire
// as a 2-cycle NOP.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int OP_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    instr_class_e    ic;
    logic            mem_last;
    logic [2:0]      dec_alu_op;
    logic            dec_imm_s;
    logic            dec_rt_imm_s;

    assign opcode   = bus.opcode;
    assign funct    = bus.funct;
    assign ic       = classify(opcode, funct);
    assign mem_last = (wait_cnt_q == MEM_WAIT_C);

    mips_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct    (funct),
        .state    (state_q),
        .alu_op   (dec_alu_op),
        .imm_s    (dec_imm_s),
        .rt_imm_s (dec_rt_imm_s)
    );

    // NOTE: state flops use non-blocking assignments and a reset sampled
    // on the clock edge, so every flop updates together from _d values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IF;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                unique case (ic)
                    IC_J, IC_JAL, IC_JR: state_d = S_IF;
`ifdef ILLEGAL_TRAP_EN
                    IC_ILL:              state_d = S_HALT;
`else
                    IC_ILL:              state_d = S_IF;
`endif
                    default:             state_d = S_EX;
                endcase
            end
            S_EX: begin
                unique case (ic)
                    IC_LW, IC_SW:   state_d = S_MEM;
                    IC_BEQ, IC_BNE: state_d = S_IF;
                    default:        state_d = S_WB;
                endcase
            end
            // Counter counts the extra wait cycles; it is back at 0 on exit.
            S_MEM: begin
                if (mem_last) begin
                    wait_cnt_d = '0;
                    state_d    = (ic == IC_LW) ? S_WB : S_IF;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Reset gates every output so no write enable coincides with rst.
    always_comb begin
        bus.PC_Write   = 1'b0;
        bus.IR_Write   = 1'b0;
        bus.PC_s       = PC_SEQ;
        bus.Write_Reg  = 1'b0;
        bus.w_r_s      = WR_RD;
        bus.wr_data_s  = WD_ALU;
        bus.rt_imm_s   = 1'b0;
        bus.imm_s      = 1'b0;
        bus.ALU_OP     = ALU_AND;
        bus.Mem_Write  = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.ALU_OP   = dec_alu_op;
            bus.imm_s    = dec_imm_s;
            bus.rt_imm_s = dec_rt_imm_s;
            unique case (state_q)
                S_IF: begin
                    bus.IR_Write = 1'b1;
                    bus.PC_Write = 1'b1;
                end
                S_ID: begin
                    unique case (ic)
                        IC_J, IC_JAL: begin
                            bus.PC_Write   = 1'b1;
                            bus.PC_s       = PC_JMP;
                            bus.instr_done = 1'b1;
                            if (ic == IC_JAL) begin
                                bus.Write_Reg = 1'b1;
                                bus.w_r_s     = WR_RA;
                                bus.wr_data_s = WD_PC4;
                            end
                        end
                        IC_JR: begin
                            bus.PC_Write   = 1'b1;
                            bus.PC_s       = PC_JR;
                            bus.instr_done = 1'b1;
                        end
                        IC_ILL: begin
                            bus.illegal    = 1'b1;
                            bus.instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EX: begin
                    if (ic == IC_BEQ || ic == IC_BNE) begin
                        bus.PC_Write   = (ic == IC_BEQ) ? bus.ZF : !bus.ZF;
                        bus.PC_s       = PC_BR;
                        bus.instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    if (ic == IC_SW && mem_last) begin
                        bus.Mem_Write  = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                end
                S_WB: begin
                    bus.Write_Reg  = 1'b1;
                    bus.w_r_s      = (ic == IC_R) ? WR_RD : WR_RT;
                    bus.wr_data_s  = (ic == IC_LW) ? WD_MEM : WD_ALU;
                    bus.instr_done = 1'b1;
                end
                S_HALT:  bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
